fetch_unit: RTL and testbench

//   Instruction fetch stage. Holds the architectural PC and fetches one word
//   per instruction from instruction memory over a req/gnt/rvalid handshake.
//   It presents instr/pc/pc+4 to decode over valid/ready, and accepts redirects
//   (taken branch, jal, jr) from the next-PC logic.
//   The block keeps at most one memory request outstanding.
//

---
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: redirect, instruction-memory and decode-side signals of the fetch stage
interface fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_4;
  logic        id_adel;
  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_4, id_adel
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_4, id_adel
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches one word per instruction with a single
// outstanding imem request, and hands instr/pc/pc+4 to decode over valid/ready
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, id_pc_q, id_pc_d;
  logic        drop_q, drop_d, adel_q, adel_d;
  logic        aligned;
  assign aligned       = pc_q[1:0] == 2'b00;
  assign bus.imem_req  = rst_n && state_q == REQ && aligned;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = state_q == HOLD;
  assign bus.id_instr  = instr_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc_4   = id_pc_q + 32'd4;
  assign bus.id_adel   = adel_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      instr_q <= '0;
      id_pc_q <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      adel_q  <= adel_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    adel_d  = adel_q;
    unique case (state_q)
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (aligned && bus.imem_gnt) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end else if (!aligned) begin
          id_pc_d = pc_q;
          instr_d = '0;
          adel_d  = 1'b1;
          state_d = HOLD;
        end else if (bus.imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          // a response landing with the redirect is already stale, so no drop is owed
          pc_d    = bus.redirect_pc;
          drop_d  = !bus.imem_rvalid;
          state_d = bus.imem_rvalid ? REQ : WAIT;
        end else if (bus.imem_rvalid && drop_q) begin
          drop_d  = 1'b0;
          state_d = REQ;
        end else if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          id_pc_d = pc_q;
          adel_d  = 1'b0;
          pc_d    = pc_q + 32'd4;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = REQ;
        end else if (bus.id_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios with a scripted imem responder and
// a scoreboard of expected fetch addresses and decode outputs
module tb_fetch_unit;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic adel;} out_t;
  logic        clk;
  logic        rst_n;
  int          vec = 0, errs = 0, acc_cnt = 0, grants_left = 0, lat = 1, cnt = 0;
  logic [31:0] pend = '0;
  out_t        exp_q[$];
  logic [31:0] addr_q[$];
  fetch_if bus ();
  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word(logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_out(logic [31:0] pc, logic adel);
    out_t e;
    e.pc    = pc;
    e.instr = adel ? 32'h0 : word(pc);
    e.adel  = adel;
    exp_q.push_back(e);
  endtask
  task automatic wait_acc(int target);
    int k = 0;
    while (acc_cnt < target && k < 60) begin
      step();
      k++;
    end
    chk("acc_count", acc_cnt, target);
  endtask
  task automatic wait_grant();
    int k = 0;
    while (grants_left != 0 && k < 40) begin
      step();
      k++;
    end
    chk("grant_seen", grants_left, 0);
  endtask
  task automatic wait_valid();
    int k = 0;
    while (!bus.id_valid && k < 40) begin
      step();
      k++;
    end
    chk("id_valid_seen", bus.id_valid, 1);
  endtask
  // imem responder: grants from a budget, returns data lat cycles after gnt
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = pend;
        end
      end
      bus.imem_gnt = 1'b0;
      if (bus.imem_req && grants_left > 0) begin
        bus.imem_gnt = 1'b1;
        grants_left--;
        pend = word(bus.imem_addr);
        cnt  = lat;
        if (addr_q.size() == 0) chk("unexpected_fetch", bus.imem_addr, 32'hxxxx_xxxx);
        else chk("fetch_addr", bus.imem_addr, addr_q.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && bus.id_valid && bus.id_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_id_pc", bus.id_pc, 32'hxxxx_xxxx);
      end else begin
        out_t e;
        e = exp_q.pop_front();
        chk("id_pc", bus.id_pc, e.pc);
        chk("id_instr", bus.id_instr, e.instr);
        chk("id_adel", {31'd0, bus.id_adel}, {31'd0, e.adel});
        chk("id_pc_4", bus.id_pc_4, e.pc + 32'd4);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_id_valid", {31'd0, bus.id_valid}, 0);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 0);
    chk("rst_id_pc", bus.id_pc, 0);
    chk("rst_id_instr", bus.id_instr, 0);
    chk("rst_id_adel", {31'd0, bus.id_adel}, 0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0000_3000);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(32'h3000 + 32'(4 * i));
      push_out(32'h3000 + 32'(4 * i), 1'b0);
    end
    grants_left = 3;
    wait_acc(3);
    bus.id_ready = 1'b0;
    addr_q.push_back(32'h300C);
    push_out(32'h300C, 1'b0);
    grants_left = 1;
    wait_valid();
    repeat (5) begin
      chk("hold_instr", bus.id_instr, word(32'h300C));
      chk("hold_pc", bus.id_pc, 32'h300C);
      chk("hold_req", {31'd0, bus.imem_req}, 0);
      step();
    end
    addr_q.push_back(32'h3010);
    push_out(32'h3010, 1'b0);
    grants_left = 1;
    bus.id_ready = 1'b1;
    wait_acc(5);
    addr_q.push_back(32'h3014);
    lat = 4;
    grants_left = 1;
    wait_grant();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3100;
    step();
    bus.redirect_valid = 1'b0;
    lat = 1;
    addr_q.push_back(32'h3100);
    push_out(32'h3100, 1'b0);
    grants_left = 1;
    wait_acc(6);
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h3002;
    step();
    bus.redirect_valid = 1'b0;
    chk("adel_no_req", {31'd0, bus.imem_req}, 0);
    push_out(32'h3002, 1'b1);
    wait_valid();
    chk("adel_hold_no_req", {31'd0, bus.imem_req}, 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    bus.id_ready       = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    chk("acc_with_redirect", acc_cnt, 7);
    addr_q.push_back(32'hFFFF_FFFC);
    addr_q.push_back(32'h0000_0000);
    push_out(32'hFFFF_FFFC, 1'b0);
    push_out(32'h0000_0000, 1'b0);
    grants_left = 2;
    wait_acc(9);
    addr_q.push_back(32'h0000_0004);
    lat = 4;
    grants_left = 1;
    wait_grant();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_id_valid", {31'd0, bus.id_valid}, 0);
    chk("arst_imem_req", {31'd0, bus.imem_req}, 0);
    chk("arst_id_pc", bus.id_pc, 0);
    chk("arst_id_instr", bus.id_instr, 0);
    chk("arst_imem_addr", bus.imem_addr, 32'h0000_3000);
    #2 rst_n = 1'b1;
    repeat (6) step();
    lat = 1;
    addr_q.push_back(32'h3000);
    push_out(32'h3000, 1'b0);
    grants_left = 1;
    wait_acc(10);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
